// File: rtl/aes_key_expand_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_expand_if
//  Description : Bundle of the key-schedule request/readout signals and the
//                shared S-box request/return path.
//  Revision    : 1.0 - initial release
// ============================================================================
interface aes_key_expand_if;
  logic [255:0] key;
  logic [1:0]   keylen;
  logic         key_init;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic         key_ready;
  logic         busy;
  logic         key_err;
  logic         sbox_req;
  logic [31:0]  sbox_feed;
  logic [31:0]  new_sbox;

  // Requester / S-box provider side
  modport master (
    output key, keylen, key_init, round, new_sbox,
    input  round_key, key_ready, busy, key_err, sbox_req, sbox_feed
  );

  // Key-expansion engine side
  modport slave (
    input  key, keylen, key_init, round, new_sbox,
    output round_key, key_ready, busy, key_err, sbox_req, sbox_feed
  );
endinterface
`default_nettype wire

// File: rtl/aes_key_expand.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_expand
//  Description : Iterative AES-128/192/256 key schedule. Produces one schedule
//                word per step, borrowing a shared external S-box with a fixed
//                latency of SBOX_LAT cycles for the SubWord steps. The full
//                60-word schedule is held in storage and read out one round
//                key at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_key_expand #(
  parameter int SBOX_LAT = 1   // legal range 1..4
) (
  input  wire logic       aclk,
  input  wire logic       aresetn,
  aes_key_expand_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_CALC      = 3'd2,
    S_SBOX_WAIT = 3'd3,
    S_WRITE     = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  // Last value of the wait counter before the S-box result is usable.
  localparam logic [1:0] WAIT_LAST   = 2'(SBOX_LAT - 1);
  localparam logic [1:0] KEYLEN_RSVD = 2'b11;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t       state_q,     state_d;
  logic [255:0] key_q,       key_d;
  logic [1:0]   keylen_q,    keylen_d;
  logic [5:0]   i_q,         i_d;        // index of the next word to produce
  logic [2:0]   j_q,         j_d;        // i mod Nk, tracked incrementally
  logic [7:0]   rcon_q,      rcon_d;
  logic [1:0]   cnt_q,       cnt_d;      // S-box wait counter
  logic         key_ready_q, key_ready_d;
  logic         key_err_q,   key_err_d;
  logic         sbox_req_q,  sbox_req_d;
  logic [31:0]  sbox_feed_q, sbox_feed_d;

  // Schedule word storage; contents are only meaningful while key_ready is set.
  logic [31:0]  words_q [60];

  // Storage write controls produced by the FSM
  logic         load_en;
  logic         wr_en;
  logic [31:0]  wr_data;

  // Mode-dependent constants derived from the latched key length
  logic [5:0]   nk;
  logic [5:0]   nw;
  logic [3:0]   nr;

  // Helper values for the word being computed
  logic [31:0]  w_prev;      // w[i-1]
  logic [31:0]  w_back;      // w[i-Nk]
  logic [31:0]  w_rot;       // RotWord(w[i-1])
  logic         is_subword;
  logic [2:0]   j_next;
  logic [7:0]   rcon_xt;

  // Readout helpers
  logic         rd_ok;
  logic [5:0]   rd_base;

  // Decode Nk / Nr / total word count for the latched mode
  always_comb begin
    nk = 6'd4;
    nr = 4'd10;
    nw = 6'd44;
    case (keylen_q)
      2'b00: begin
        nk = 6'd4;
        nr = 4'd10;
        nw = 6'd44;
      end
      2'b01: begin
        nk = 6'd6;
        nr = 4'd12;
        nw = 6'd52;
      end
      default: begin
        nk = 6'd8;
        nr = 4'd14;
        nw = 6'd60;
      end
    endcase
  end

  // Operand fetch and per-word classification
  always_comb begin
    w_prev     = words_q[i_q - 6'd1];
    w_back     = words_q[i_q - nk];
    w_rot      = {w_prev[23:0], w_prev[31:24]};
    // AES-256 inserts an extra SubWord (no rotate, no Rcon) half-way through each key block.
    is_subword = (j_q == 3'd0) || ((nk == 6'd8) && (j_q == 3'd4));
    j_next     = (j_q == 3'(nk - 6'd1)) ? 3'd0 : (j_q + 3'd1);
    rcon_xt    = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
  end

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    keylen_d    = keylen_q;
    i_d         = i_q;
    j_d         = j_q;
    rcon_d      = rcon_q;
    cnt_d       = cnt_q;
    key_ready_d = key_ready_q;
    key_err_d   = 1'b0;
    sbox_req_d  = 1'b0;
    sbox_feed_d = sbox_feed_q;
    load_en     = 1'b0;
    wr_en       = 1'b0;
    wr_data     = 32'h0;

    case (state_q)
      S_IDLE: begin
        if (bus.key_init) begin
          if (bus.keylen == KEYLEN_RSVD) begin
            key_err_d = 1'b1;
          end else begin
            key_d       = bus.key;
            keylen_d    = bus.keylen;
            key_ready_d = 1'b0;
            state_d     = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        load_en = 1'b1;
        i_d     = nk;
        j_d     = 3'd0;
        rcon_d  = 8'h01;
        state_d = S_CALC;
      end

      S_CALC: begin
        if (i_q == nw) begin
          state_d = S_DONE;
        end else if (is_subword) begin
          sbox_feed_d = (j_q == 3'd0) ? w_rot : w_prev;
          sbox_req_d  = 1'b1;
          cnt_d       = 2'd0;
          state_d     = S_SBOX_WAIT;
        end else begin
          wr_en   = 1'b1;
          wr_data = w_back ^ w_prev;
          i_d     = i_q + 6'd1;
          j_d     = j_next;
        end
      end

      S_SBOX_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end

      S_WRITE: begin
        wr_en = 1'b1;
        if (j_q == 3'd0) begin
          wr_data = w_back ^ bus.new_sbox ^ {rcon_q, 24'h0};
          rcon_d  = rcon_xt;
        end else begin
          wr_data = w_back ^ bus.new_sbox;
        end
        i_d     = i_q + 6'd1;
        j_d     = j_next;
        state_d = S_CALC;
      end

      S_DONE: begin
        key_ready_d = 1'b1;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and control registers with synchronous active-low reset
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      key_q       <= '0;
      keylen_q    <= 2'b00;
      i_q         <= 6'd0;
      j_q         <= 3'd0;
      rcon_q      <= 8'h00;
      cnt_q       <= 2'd0;
      key_ready_q <= 1'b0;
      key_err_q   <= 1'b0;
      sbox_req_q  <= 1'b0;
      sbox_feed_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      keylen_q    <= keylen_d;
      i_q         <= i_d;
      j_q         <= j_d;
      rcon_q      <= rcon_d;
      cnt_q       <= cnt_d;
      key_ready_q <= key_ready_d;
      key_err_q   <= key_err_d;
      sbox_req_q  <= sbox_req_d;
      sbox_feed_q <= sbox_feed_d;
    end
  end

  // Word storage: bulk load of the cipher key words, otherwise one word per step
  always_ff @(posedge aclk) begin
    if (load_en) begin
      for (int k = 0; k < 8; k++) begin
        if (6'(k) < nk) begin
          words_q[k] <= key_q[255 - 32*k -: 32];
        end
      end
    end else if (wr_en) begin
      words_q[i_q] <= wr_data;
    end
  end

  // Round-key readout; zero unless a complete schedule exists and the round is in range
  always_comb begin
    rd_ok   = key_ready_q && (bus.round <= nr);
    rd_base = rd_ok ? {bus.round, 2'b00} : 6'd0;
    if (rd_ok) begin
      bus.round_key = {words_q[rd_base],
                       words_q[rd_base + 6'd1],
                       words_q[rd_base + 6'd2],
                       words_q[rd_base + 6'd3]};
    end else begin
      bus.round_key = 128'h0;
    end
  end

  assign bus.key_ready = key_ready_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.key_err   = key_err_q;
  assign bus.sbox_req  = sbox_req_q;
  assign bus.sbox_feed = sbox_feed_q;

endmodule
`default_nettype wire

// File: doc/aes_key_expand.md
AES_KEY_EXPAND -- requirements
Module: aes_key_expand

Interface
REQ-001 Parameter SBOX_LAT, default 1, SHALL give the fixed external S-box latency in cycles from sbox_feed update to valid new_sbox; legal range 1..4.
REQ-002 aclk  in  1  SHALL be the clock; every register updates on its rising edge.
REQ-003 aresetn  in  1  SHALL be the reset: synchronous, active-low; clock aclk.
REQ-004 key  in  256  SHALL carry the cipher key, MSB-aligned: AES-128 uses [255:128]; AES-192 uses [255:64]; AES-256 uses [255:0].
REQ-005 keylen  in  2  SHALL select the mode: 00=AES-128 (Nk=4, Nr=10), 01=AES-192 (Nk=6, Nr=12), 10=AES-256 (Nk=8, Nr=14), 11=reserved.
REQ-006 key_init  in  1  SHALL be a start request, sampled only in IDLE.
REQ-007 round  in  4  SHALL be the round-key read index, 0..Nr.
REQ-008 round_key  out  128  SHALL give words w[4*round .. 4*round+3], with w[4*round] in [127:96].
REQ-009 key_ready  out  1  SHALL flag that the schedule is complete and valid.
REQ-010 busy  out  1  SHALL be high in every state except IDLE.
REQ-011 key_err  out  1  SHALL be a one-cycle pulse flagging a rejected key_init.
REQ-012 sbox_req  out  1  SHALL be a one-cycle pulse marking a new sbox_feed value.
REQ-013 sbox_feed  out  32  SHALL be the registered word sent to the shared S-box.
REQ-014 new_sbox  in  32  SHALL be the bytewise S-box substitution of sbox_feed, valid exactly SBOX_LAT cycles after sbox_req.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, CALC, SBOX_WAIT, WRITE and DONE.
REQ-016 IDLE: key_init=1 with keylen≠11 SHALL latch key and keylen, clear key_ready, and go to LOAD.
REQ-016a IDLE: key_init=1 with keylen=11 SHALL stay in IDLE, pulse key_err, and leave key_ready unchanged.
REQ-017 LOAD SHALL last 1 cycle: write w[0..Nk-1] from the latched key, set i=Nk and Rcon=0x01, then go to CALC.
REQ-018 CALC, plain word (i mod Nk≠0, and not (Nk=8 and i mod 8=4)): w[i]=w[i-Nk]^w[i-1], written in the same cycle, i++.
REQ-019 CALC, SubWord word: drive sbox_feed (RotWord(w[i-1]) when i mod Nk=0, else w[i-1]), pulse sbox_req, then go to SBOX_WAIT.
REQ-020 SBOX_WAIT SHALL last exactly SBOX_LAT cycles, then go to WRITE.
REQ-021 WRITE, i mod Nk=0: w[i]=w[i-Nk]^new_sbox^{Rcon,24'h0}, and Rcon SHALL become xtime(Rcon) ({Rcon[6:0],0} ^ 0x1b when Rcon[7]=1).
REQ-021a WRITE, other SubWord words: w[i]=w[i-Nk]^new_sbox, Rcon unchanged; in both WRITE cases i++ and return to CALC.
REQ-022 When i reaches 4*(Nr+1) (44/52/60), the FSM SHALL go to DONE; DONE SHALL last 1 cycle, set key_ready, and go to IDLE.
REQ-023 Cost per word: plain 1 cycle, SubWord 2+SBOX_LAT cycles; with key_init accepted at edge 0, key_ready SHALL rise at edge 3+G, G=(Nw-Nk)+(1+SBOX_LAT)*S.
REQ-023a S SHALL be 10 for AES-128, 8 for AES-192 and 13 for AES-256.
REQ-024 round_key SHALL be combinational from word storage (60x32), forced to 0 while key_ready=0 or round>Nr.
REQ-025 key_init while busy=1 SHALL be ignored, with no key_err.
REQ-026 key_ready SHALL stay high through IDLE until the next accepted key_init.
REQ-027 Rcon arithmetic SHALL be 8-bit, and all XORs 32-bit with no carries.

Reset
REQ-028 aresetn=0 SHALL force IDLE and clear key_ready, busy, key_err, sbox_req, sbox_feed, i and Rcon to 0; word storage need not clear.
REQ-029 Reset mid-expansion SHALL abort the run; round_key SHALL read 0 until a later run completes; a late new_sbox SHALL be ignored.

Verification
REQ-030 AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, SBOX_LAT=1 -> key_ready at edge 63; round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-031 AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> key_ready at edge 65; round 12 = e98ba06f448c773c8ecc720401002202.
REQ-032 AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> key_ready at edge 81; round 14 = fe4890d1e6188d0b046df344706c631e.
REQ-033 keylen=11 with key_init -> key_err high 1 cycle, busy stays 0; key_init during busy -> ignored, result unchanged.
REQ-034 Reset at edge 20 of the AES-128 run -> busy=0, key_ready=0, round_key=0; restart -> same values as REQ-030.
REQ-035 SBOX_LAT=3, AES-128 vector -> key_ready at edge 83 with identical round keys; round=11 -> round_key=0.
